vx_perf_cache_aggregator: RTL and testbench
===========================================

# vx_perf_cache_aggregator

Request-driven aggregator that sums one selected cache performance counter across several cache instances using a single shared adder. It sits between the per-cache perf counter bundles (reads, writes, read/write misses, bank/MSHR/mem/crsp stalls) and the CSR/perf readout logic. Each accepted request snapshots the counter column, then accumulates one cache per cycle before returning the total on a valid/ready response port.

## Interface
- NUM_CACHES, default 4: number of cache perf bundles aggregated; must be ≥ 1.
- CTR_BITS, default `PERF_CTR_BITS`: width of each input counter.
- SUM_BITS, derived, CTR_BITS + $clog2(NUM_CACHES) (CTR_BITS+1 when NUM_CACHES=1): response width; the sum never overflows.
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- cache_ctrs  in  NUM_CACHES*8*CTR_BITS  flattened counters; counter k of cache c at [(c*8+k)*CTR_BITS +: CTR_BITS]; k order: 0 reads, 1 writes, 2 read_misses, 3 write_misses, 4 bank_stalls, 5 mshr_stalls, 6 mem_stalls, 7 crsp_stalls.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_ctr_id  in  3  counter index k to aggregate.
- req_cache_mask  in  NUM_CACHES  bit c=1 includes cache c in the sum.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_data  out  SUM_BITS  sum of selected counters.
- rsp_ctr_id  out  3  echo of accepted req_ctr_id.
- rsp_count  out  $clog2(NUM_CACHES+1)  number of caches included (popcount of mask).
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCUM, RESP.
- IDLE: req_ready=1. On req_valid: capture cache_ctrs column k=req_ctr_id for all caches into a NUM_CACHES×CTR_BITS snapshot, capture mask and ctr_id, clear accumulator and count, idx=0, go ACCUM.
- ACCUM: each cycle, if mask[idx], acc += zero-extended snap[idx] and count += 1; idx += 1. After the cycle that processes idx=NUM_CACHES-1, go RESP. No early exit: every cache slot costs one cycle regardless of mask.
- RESP: rsp_valid=1; rsp_data=acc, rsp_ctr_id, rsp_count stable until handshake. On rsp_ready, go IDLE.
- Snapshot isolation: changes on cache_ctrs after the accept cycle never affect the response.
- All-zero mask: rsp_data=0, rsp_count=0, same latency.
- Max-value inputs: all NUM_CACHES counters at 2^CTR_BITS-1 sum exactly, no wrap, no saturation.
- req_ready is 0 in ACCUM and RESP; requests there are ignored (requester holds valid).
- req_ctr_id is 3 bits, so every value is legal.

## Timing
- Reset (async assert, any state): state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, rsp_ctr_id=0, rsp_count=0, busy=0, idx=0. An in-flight request is dropped with no response.
- Accept at edge T (req_valid&&req_ready high in cycle T): ACCUM for cycles T+1..T+NUM_CACHES; rsp_valid first high in cycle T+NUM_CACHES+1.
- Response handshake in cycle R: IDLE in R+1, req_ready=1 in R+1. A new request can be accepted no earlier than R+1; no same-cycle response-to-request overlap.
- rsp_valid, once high, stays high with stable payload until rsp_ready; rsp_ready while rsp_valid=0 has no effect.
- All outputs are registered or decoded from state only; no combinational path from req_*/rsp_ready to outputs.

## Test plan
- Reset then NUM_CACHES=4, CTR_BITS=44: counter 2 (read_misses) = {10,20,30,40}, mask 4'b1111 accepted at T -> rsp_valid at T+5, rsp_data=100, rsp_ctr_id=2, rsp_count=4.
- Mask 4'b0101, counter 7 = {5,999,7,999} -> rsp_data=12, rsp_count=2; mask 4'b0000 -> rsp_data=0, rsp_count=0, still at T+5.
- All four counter-0 values = 2^44-1, mask 4'b1111 -> rsp_data = 4*(2^44-1) (46 bits), no wrap.
- Accept, then change all cache_ctrs to 0 in T+1 -> response still equals the values captured at T; req_valid held during ACCUM/RESP is not accepted (req_ready=0).
- Hold rsp_ready=0 for 10 cycles after rsp_valid -> payload stable, busy=1; assert rsp_ready -> req_ready=1 next cycle, back-to-back request accepted there, second response 5 cycles later.
- Drop reset_n low in ACCUM cycle 2 -> rsp_valid stays 0, busy=0 and req_ready=1 immediately; after release, new request completes normally.

Source files
------------

// File: rtl/vx_perf_cache_aggregator_if.sv
// rtl/vx_perf_cache_aggregator_if.sv - request/response handshake bundle for the perf cache aggregator
interface vx_perf_cache_aggregator_if #(
  parameter int NUM_CACHES = 4,
  parameter int CTR_BITS   = 44
);
  localparam int SUM_BITS = (NUM_CACHES == 1) ? CTR_BITS + 1 : CTR_BITS + $clog2(NUM_CACHES);
  localparam int CNT_BITS = $clog2(NUM_CACHES + 1);

  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_ctr_id;
  logic [NUM_CACHES-1:0] req_cache_mask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [SUM_BITS-1:0]   rsp_data;
  logic [2:0]            rsp_ctr_id;
  logic [CNT_BITS-1:0]   rsp_count;

  modport master (
    output req_valid, req_ctr_id, req_cache_mask, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_ctr_id, rsp_count
  );

  modport slave (
    input  req_valid, req_ctr_id, req_cache_mask, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_ctr_id, rsp_count
  );
endinterface

// File: rtl/vx_perf_cache_aggregator.sv
// rtl/vx_perf_cache_aggregator.sv - sums one selected perf counter across caches with a single shared adder
module vx_perf_cache_aggregator #(
  parameter int NUM_CACHES = 4,
  parameter int CTR_BITS   = 44
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CACHES*8*CTR_BITS-1:0] cache_ctrs,
  output logic                           busy,
  vx_perf_cache_aggregator_if.slave      bus
);
  localparam int SUM_BITS = (NUM_CACHES == 1) ? CTR_BITS + 1 : CTR_BITS + $clog2(NUM_CACHES);
  localparam int CNT_BITS = $clog2(NUM_CACHES + 1);
  localparam int IDX_BITS = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESP} state_e;

  state_e                state_q, state_d;
  logic [CTR_BITS-1:0]   snap_q [NUM_CACHES];
  logic [CTR_BITS-1:0]   snap_d [NUM_CACHES];
  logic [NUM_CACHES-1:0] mask_q, mask_d;
  logic [2:0]            id_q, id_d;
  logic [SUM_BITS-1:0]   acc_q, acc_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [IDX_BITS-1:0]   idx_q, idx_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      for (int c = 0; c < NUM_CACHES; c++) snap_q[c] <= '0;
      mask_q  <= '0;
      id_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      for (int c = 0; c < NUM_CACHES; c++) snap_q[c] <= snap_d[c];
      mask_q  <= mask_d;
      id_q    <= id_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    for (int c = 0; c < NUM_CACHES; c++) snap_d[c] = snap_q[c];
    mask_d  = mask_q;
    id_d    = id_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          // Snapshot the whole column now so later counter movement cannot leak into the sum.
          for (int c = 0; c < NUM_CACHES; c++)
            snap_d[c] = cache_ctrs[(c*8 + int'(bus.req_ctr_id))*CTR_BITS +: CTR_BITS];
          mask_d  = bus.req_cache_mask;
          id_d    = bus.req_ctr_id;
          acc_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (mask_q[idx_q]) begin
          acc_d = acc_q + SUM_BITS'(snap_q[idx_q]);
          cnt_d = cnt_q + CNT_BITS'(1);
        end
        if (idx_q == IDX_BITS'(NUM_CACHES - 1)) begin
          idx_d   = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + IDX_BITS'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign busy           = (state_q != IDLE);
  assign bus.rsp_data   = acc_q;
  assign bus.rsp_ctr_id = id_q;
  assign bus.rsp_count  = cnt_q;
endmodule

// File: tb/tb_vx_perf_cache_aggregator.sv
// tb/tb_vx_perf_cache_aggregator.sv - directed and randomized checks of the perf cache aggregator
module tb_vx_perf_cache_aggregator;
  localparam int N  = 4;
  localparam int CB = 44;
  localparam int SB = 46;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [N*8*CB-1:0] cache_ctrs;
  logic              busy;

  vx_perf_cache_aggregator_if #(.NUM_CACHES(N), .CTR_BITS(CB)) bus ();

  vx_perf_cache_aggregator #(.NUM_CACHES(N), .CTR_BITS(CB)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cache_ctrs (cache_ctrs),
    .busy       (busy),
    .bus        (bus)
  );

  logic [CB-1:0] ctr [N][8];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 8; k++)
        cache_ctrs[(c*8+k)*CB +: CB] = ctr[c][k];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ctrs();
    logic [63:0] r;
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 8; k++) begin
        r = {$urandom, $urandom};
        ctr[c][k] = ($urandom_range(0, 5) == 0) ? {CB{1'b1}} : r[CB-1:0];
      end
  endtask

  // Issue one request and check the whole transaction against a sum computed from the counter table.
  task automatic run_txn(input logic [2:0] id, input logic [N-1:0] mask, input int hold,
                         input bit zero_after, input bit rst_mid);
    logic [SB-1:0] exp_sum;
    int            exp_cnt;
    int            n;
    exp_sum = '0;
    exp_cnt = 0;
    for (int c = 0; c < N; c++)
      if (mask[c]) begin
        exp_sum = exp_sum + SB'(ctr[c][id]);
        exp_cnt++;
      end
    pack();
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid      = 1'b1;
    bus.req_ctr_id     = id;
    bus.req_cache_mask = mask;
    step();
    if (zero_after) begin
      for (int c = 0; c < N; c++)
        for (int k = 0; k < 8; k++) ctr[c][k] = '0;
      pack();
      bus.req_ctr_id     = ~id;
      bus.req_cache_mask = ~mask;
    end else begin
      bus.req_valid = 1'b0;
    end
    chk("busy_accum", 64'(busy), 64'd1);
    chk("req_ready_accum", 64'(bus.req_ready), 64'd0);
    if (rst_mid) begin
      step();
      reset_n = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      bus.req_valid = 1'b0;
      step();
      chk("rst_rsp_valid_held", 64'(bus.rsp_valid), 64'd0);
      reset_n = 1'b1;
      return;
    end
    n = 1;
    while (!bus.rsp_valid && n < 20) begin
      if (zero_after) chk("req_ready_held_valid", 64'(bus.req_ready), 64'd0);
      step();
      n++;
    end
    bus.req_valid = 1'b0;
    chk("latency", 64'(n), 64'(N + 1));
    chk("rsp_data", 64'(bus.rsp_data), 64'(exp_sum));
    chk("rsp_ctr_id", 64'(bus.rsp_ctr_id), 64'(id));
    chk("rsp_count", 64'(bus.rsp_count), 64'(exp_cnt));
    chk("busy_resp", 64'(busy), 64'd1);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_rsp_data", 64'(bus.rsp_data), 64'(exp_sum));
      chk("hold_rsp_count", 64'(bus.rsp_count), 64'(exp_cnt));
      chk("hold_busy", 64'(busy), 64'd1);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("req_ready_after_rsp", 64'(bus.req_ready), 64'd1);
    chk("rsp_valid_after_rsp", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    reset_n            = 1'b0;
    cache_ctrs         = '0;
    bus.req_valid      = 1'b0;
    bus.req_ctr_id     = '0;
    bus.req_cache_mask = '0;
    bus.rsp_ready      = 1'b0;
    for (int c = 0; c < N; c++)
      for (int k = 0; k < 8; k++) ctr[c][k] = '0;
    step();
    step();
    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
    chk("reset_rsp_ctr_id", 64'(bus.rsp_ctr_id), 64'd0);
    chk("reset_rsp_count", 64'(bus.rsp_count), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    step();

    randomize_ctrs();
    ctr[0][2] = 44'd10; ctr[1][2] = 44'd20; ctr[2][2] = 44'd30; ctr[3][2] = 44'd40;
    run_txn(3'd2, 4'b1111, 0, 1'b0, 1'b0);

    ctr[0][7] = 44'd5; ctr[1][7] = 44'd999; ctr[2][7] = 44'd7; ctr[3][7] = 44'd999;
    run_txn(3'd7, 4'b0101, 0, 1'b0, 1'b0);
    run_txn(3'd7, 4'b0000, 0, 1'b0, 1'b0);

    for (int c = 0; c < N; c++) ctr[c][0] = {CB{1'b1}};
    run_txn(3'd0, 4'b1111, 1, 1'b0, 1'b0);

    randomize_ctrs();
    run_txn(3'd4, 4'b1011, 0, 1'b1, 1'b0);

    randomize_ctrs();
    run_txn(3'd5, 4'b1111, 10, 1'b0, 1'b0);
    run_txn(3'd3, 4'b0110, 0, 1'b0, 1'b0);

    randomize_ctrs();
    run_txn(3'd1, 4'b1111, 0, 1'b0, 1'b1);
    step();
    run_txn(3'd6, 4'b1001, 0, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      randomize_ctrs();
      run_txn(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 1) == 1) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
